// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store unit: memory op codes (also used by
// the execute stage), LSU state encoding and small op classification helpers.
package lsu_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [31:0] ZERO = 32'd0;

    // Codes outside the table (9..15) are treated like MEM_NOP.
    function automatic logic is_mem_op(mem_op_e op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
            MEM_SB, MEM_SH, MEM_SW: is_mem_op = 1'b1;
            default:                is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(mem_op_e op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: is_misaligned = addr_lo[0];
            MEM_LW, MEM_SW:          is_misaligned = (addr_lo != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_fmt.sv
// Combinational lane formatting: byte enables and replicated store data on the
// way out, byte/half selection and sign/zero extension on the way back.
module lsu_fmt
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext
);

    mem_op_e     op_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op_e     = mem_op_e'(op);
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be       = 4'b0000;
        wdata_al = wdata;
        case (op_e)
            MEM_LB, MEM_LBU, MEM_SB: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            MEM_LW, MEM_SW: be = 4'b1111;
            default:        be = 4'b0000;
        endcase
    end

    always_comb begin
        rdata_ext = ZERO;
        case (op_e)
            MEM_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: rdata_ext = {24'd0, byte_sel};
            MEM_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: rdata_ext = {16'd0, half_sel};
            MEM_LW:  rdata_ext = rdata;
            default: rdata_ext = ZERO;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer: accepts one memory op from execute, runs a req/gnt/rvalid
// bus transaction, stalls the pipeline until retirement and writes back loads.
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [4:0]        rd_i,
    output logic              stall_o,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [4:0]        rd_q;
    logic              wb_q;
    logic [CNT_W-1:0]  cnt_q;

    mem_op_e           op_in;
    logic              accept;
    logic              misaligned;
    logic              latch_en;
    logic              rdata_en;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_rdata;

    assign op_in      = mem_op_e'(mem_op_i);
    assign accept     = req_valid_i && is_mem_op(op_in);
    assign misaligned = is_misaligned(op_in, mem_addr_i[1:0]);

    lsu_fmt u_fmt (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus_rdata_i),
        .be        (fmt_be),
        .wdata_al  (fmt_wdata),
        .rdata_ext (fmt_rdata)
    );

    // Bus handshake: the request (bus_req_o with we/addr/be/wdata) is held
    // stable in REQ until the cycle bus_gnt_i is seen high; read data is taken
    // only in WAIT, on the first cycle bus_rvalid_i is high.
    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        rdata_en    = 1'b0;
        stall_o     = 1'b0;
        err_o       = 1'b0;
        reg_we_o    = 1'b0;
        reg_waddr_o = 5'd0;
        reg_wdata_o = '0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = 4'b0000;
        bus_wdata_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        err_o = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        stall_o  = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o     = 1'b1;
                bus_req_o   = 1'b1;
                bus_we_o    = is_store(op_q);
                bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                bus_be_o    = fmt_be;
                bus_wdata_o = fmt_wdata;
                if (bus_gnt_i && is_store(op_q)) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // A load granted on the last budgeted cycle still cannot
                    // finish in time, so it is abandoned like an ungranted one.
                    err_o   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) begin
                    rdata_en = 1'b1;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_o   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_q) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = rd_q;
                    reg_wdata_o = rdata_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 5'd0;
            wb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                op_q    <= op_in;
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                rd_q    <= rd_i;
                wb_q    <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Writes to x0 are dropped here so DONE only has to test one flag.
            if (rdata_en) begin
                rdata_q <= fmt_rdata;
                wb_q    <= (rd_q != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized scoreboard bench for lsu_bus_ctrl: a cycle-exact driver pushes the
// expected bus handshakes, writebacks and error pulses; a monitor pops them.
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  rd;
    logic        stall;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .mem_op_i     (mem_op),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .rd_i         (rd),
        .stall_o      (stall),
        .reg_we_o     (reg_we),
        .reg_waddr_o  (reg_waddr),
        .reg_wdata_o  (reg_wdata),
        .err_o        (err),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_be_o     (bus_be),
        .bus_wdata_o  (bus_wdata),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata)
    );

    typedef struct packed {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int       err_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_store(mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic bit op_signed(mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LH);
    endfunction

    function automatic logic [3:0] m_be(mem_op_e op, logic [31:0] addr);
        logic [7:0] v;
        v = ((8'd1 << op_size(op)) - 8'd1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(mem_op_e op, logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = op_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(mem_op_e op, logic [31:0] addr, logic [31:0] rdata);
        logic [63:0] v, mask;
        int n, off;
        n    = op_size(op);
        off  = int'(addr % 4);
        mask = (64'd1 << (8*n)) - 64'd1;
        v    = ({32'd0, rdata} >> (8*off)) & mask;
        if (op_signed(op) && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bus_exp_t be_e;
        wb_exp_t  wb_e;
        int       ec;
        if (!rst) begin
            if (bus_req && bus_gnt) begin
                if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    be_e = bus_q.pop_front();
                    check("bus_cyc", cyc, be_e.cyc);
                    check("bus_we", bus_we, be_e.we);
                    check("bus_addr", bus_addr, be_e.addr);
                    check("bus_be", bus_be, be_e.be);
                    check("bus_wdata", bus_wdata, be_e.wdata);
                end
            end
            if (reg_we) begin
                if (wb_q.size() == 0) check("wb_unexpected", 1, 0);
                else begin
                    wb_e = wb_q.pop_front();
                    check("wb_cyc", cyc, wb_e.cyc);
                    check("wb_addr", reg_waddr, wb_e.rd);
                    check("wb_data", reg_wdata, wb_e.data);
                end
            end
            if (err) begin
                if (err_q.size() == 0) check("err_unexpected", 1, 0);
                else begin
                    ec = err_q.pop_front();
                    check("err_cyc", cyc, ec);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd_a, input int d, input int r, input logic [31:0] rdata);
        int n, idx, wcnt;
        bit fin, in_req, to;
        n = op_size(op);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        mem_op     = op;
        mem_addr   = addr;
        mem_wdata  = wd;
        rd         = rd_a;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            check("nop_stall", stall, 0);
        end else if (addr % n != 0) begin
            err_q.push_back(cyc);
            @(negedge clk);
            check("mis_stall", stall, 0);
            check("mis_req", bus_req, 0);
        end else begin
            @(negedge clk);
            check("acc_stall", stall, 1);
            idx = 0; wcnt = 0; fin = 0; in_req = 1;
            while (!fin) begin
                @(posedge clk); #1;
                req_valid  = 1'b0;
                bus_gnt    = 1'b0;
                bus_rvalid = 1'b0;
                bus_rdata  = $urandom;
                to = 0;
                if (in_req) begin
                    if (idx == d) begin
                        bus_gnt    = 1'b1;
                        bus_rvalid = 1'b1;   // stray rvalid in the grant cycle
                        bus_q.push_back('{cyc, op_store(op), addr & 32'hFFFF_FFFC,
                                          m_be(op, addr), m_wdata(op, wd)});
                        if (op_store(op)) fin = 1;
                        else if (idx == TO - 1) to = 1;
                    end else if (idx == TO - 1) to = 1;
                end else begin
                    if (wcnt == r) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = rdata;
                        fin = 1;
                        if (rd_a != 5'd0) wb_q.push_back('{cyc + 1, rd_a, m_load(op, addr, rdata)});
                    end else if (idx == TO - 1) to = 1;
                    else wcnt++;
                end
                if (to) begin
                    err_q.push_back(cyc);
                    fin = 1;
                end
                @(negedge clk);
                check("busy_stall", stall, 1);
                check("busy_req", bus_req, in_req);
                if (in_req && bus_gnt && !fin) in_req = 0;
                idx++;
            end
            // DONE: a request presented now is the retiring op and must be ignored
            @(posedge clk); #1;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            req_valid  = 1'b1;
            mem_op     = MEM_SW;
            mem_addr   = 32'h0000_0040;
            @(negedge clk);
            check("done_stall", stall, 0);
            check("done_req", bus_req, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid  = 1'b0;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {stall, reg_we, err, bus_req, bus_we, bus_be, reg_waddr}, 0);
        check({tag, "_wbdata"}, reg_wdata, 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
    endtask

    task automatic reset_mid_load();
        @(posedge clk); #1;
        req_valid = 1'b1; mem_op = MEM_LW; mem_addr = 32'h0000_3000; rd = 5'd7;
        @(negedge clk);
        check("rst_acc_stall", stall, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; bus_gnt = 1'b1;
        bus_q.push_back('{cyc, 1'b0, 32'h0000_3000, 4'b1111, m_wdata(MEM_LW, mem_wdata)});
        @(negedge clk);
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_zero("rst_wait");
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("rst_late_we", reg_we, 0);
        check("rst_late_stall", stall, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_op_e op;
        logic [31:0] a;
        int n, off;
        rst = 1'b1; req_valid = 1'b0; mem_op = 4'd0; mem_addr = '0; mem_wdata = '0;
        rd = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(MEM_SB,  32'h0000_1003, 32'h0000_00AB, 5'd0, 1, 0, 32'h0);
        do_op(MEM_LB,  32'h0000_2001, 32'h0,         5'd5, 0, 0, 32'h0000_8000);
        do_op(MEM_LBU, 32'h0000_2001, 32'h0,         5'd5, 0, 0, 32'h0000_8000);
        do_op(MEM_LH,  32'h0000_2002, 32'h0,         5'd6, 0, 0, 32'h8001_1234);
        do_op(MEM_LHU, 32'h0000_2002, 32'h0,         5'd6, 0, 0, 32'h8001_1234);
        do_op(MEM_LW,  32'h0000_2000, 32'h0,         5'd0, 0, 0, 32'h1234_5678);
        do_op(MEM_LW,  32'h0000_2002, 32'h0,         5'd3, 0, 0, 32'h0);
        do_op(MEM_SH,  32'h0000_2006, 32'hCAFE_BEEF, 5'd0, 0, 0, 32'h0);
        do_op(MEM_LW,  32'h0000_2004, 32'h0,         5'd9, 99, 0, 32'h0);
        do_op(MEM_LW,  32'h0000_2008, 32'h0,         5'd9, 1, 5, 32'h0);
        reset_mid_load();
        do_op(MEM_SW,  32'h0000_4000, 32'h1357_9BDF, 5'd0, 0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op = mem_op_e'($urandom_range(0, 8));
            n  = op_size(op);
            a  = $urandom & 32'hFFFF_FFFC;
            if (n == 0 || $urandom_range(0, 4) == 0) off = $urandom_range(0, 3);
            else off = ($urandom_range(0, 3) / n) * n;
            do_op(op, a | off, $urandom, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2),
                  $urandom_range(0, 1), $urandom);
        end

        idle(4);
        check("bus_q_left", bus_q.size(), 0);
        check("wb_q_left", wb_q.size(), 0);
        check("err_q_left", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
